mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch and data requester ports
// plus the shared memory request/response bus.
interface mem_arbiter_if #(
  parameter int AW    = 4,
  parameter int EXTRA = 4
);
  localparam int DW = (2**EXTRA)*8;

  logic             f_req;
  logic [AW:0]      f_addr;
  logic [EXTRA-1:0] f_extra;
  logic             f_gnt;
  logic             f_valid;
  logic [DW-1:0]    f_data;
  logic             f_error;

  logic             d_req;
  logic [AW:0]      d_addr;
  logic [EXTRA-1:0] d_extra;
  logic             d_gnt;
  logic             d_valid;
  logic [DW-1:0]    d_data;
  logic             d_error;

  logic [AW:0]      mem_addr;
  logic [EXTRA-1:0] mem_extra;
  logic [DW-1:0]    mem_data;
  logic             mem_error;

  logic             busy;

  modport slave (
    input  f_req, f_addr, f_extra,
    output f_gnt, f_valid, f_data, f_error,
    input  d_req, d_addr, d_extra,
    output d_gnt, d_valid, d_data, d_error,
    output mem_addr, mem_extra,
    input  mem_data, mem_error,
    output busy
  );

  modport master (
    output f_req, f_addr, f_extra,
    input  f_gnt, f_valid, f_data, f_error,
    output d_req, d_addr, d_extra,
    input  d_gnt, d_valid, d_data, d_error,
    input  mem_addr, mem_extra,
    output mem_data, mem_error,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one
// memory between the fetch and data requesters.
module mem_arbiter #(
  parameter int AW    = 4,
  parameter int EXTRA = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             owner;
  logic             last;
  logic             any_req;
  logic             win_d;
  logic             load;
  logic [AW:0]      win_addr;
  logic [EXTRA-1:0] win_extra;

  // Tie goes to data only when fetch was served last.
  always_comb begin
    any_req   = bus.f_req | bus.d_req;
    win_d     = bus.d_req & (~bus.f_req | ~last);
    win_addr  = win_d ? bus.d_addr : bus.f_addr;
    win_extra = win_d ? bus.d_extra : bus.f_extra;
  end

  // Next state; requests are looked at in IDLE/DONE only.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          load     = 1'b1;
          state_nx = ADDR;
        end
      end
      ADDR: state_nx = DATA;
      DATA: state_nx = DONE;
      DONE: begin
        if (any_req) begin
          load     = 1'b1;
          state_nx = ADDR;
        end else begin
          state_nx = IDLE;
        end
      end
    endcase
  end

  // Grant/valid pulses decoded from state and owner.
  always_comb begin
    bus.f_gnt   = (state == ADDR) & ~owner;
    bus.d_gnt   = (state == ADDR) & owner;
    bus.f_valid = (state == DONE) & ~owner;
    bus.d_valid = (state == DONE) & owner;
    bus.busy    = (state != IDLE);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Owner, memory request and per-port read capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner         <= 1'b0;
      last          <= 1'b1;
      bus.mem_addr  <= '0;
      bus.mem_extra <= '0;
      bus.f_data    <= '0;
      bus.f_error   <= 1'b0;
      bus.d_data    <= '0;
      bus.d_error   <= 1'b0;
    end else begin
      if (load) begin
        owner         <= win_d;
        last          <= win_d;
        bus.mem_addr  <= win_addr;
        bus.mem_extra <= win_extra;
      end
      if (state == DATA) begin
        if (owner) begin
          bus.d_data  <= bus.mem_data;
          bus.d_error <= bus.mem_error;
        end else begin
          bus.f_data  <= bus.mem_data;
          bus.f_error <= bus.mem_error;
        end
      end
    end
  end

endmodule
